// File: rtl/ram_stream_reader.sv
// Streams in_length consecutive RAM words from in_base_addr onto a valid/ready port.
// A 2-entry prefetch buffer hides the RAM's registered read latency.
module ram_stream_reader #(
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int RAM_DATA_WIDTH = 8
) (
    input  logic                        in_clk,
    input  logic                        in_rst_n,
    input  logic                        in_start,
    input  logic [RAM_ADDR_WIDTH-1:0]   in_base_addr,
    input  logic [RAM_ADDR_WIDTH:0]     in_length,
    output logic                        out_busy,
    output logic                        out_done,
    output logic [RAM_ADDR_WIDTH-1:0]   out_ram_addr,
    output logic                        out_ram_wr,
    input  logic [RAM_DATA_WIDTH-1:0]   in_ram_data,
    output logic [RAM_DATA_WIDTH-1:0]   out_data,
    output logic                        out_valid,
    input  logic                        in_ready
);

    localparam int AW = RAM_ADDR_WIDTH;
    localparam int DW = RAM_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [AW:0]     len_q;
    logic [AW:0]     issued_q;
    logic [AW:0]     delivered_q;
    logic [AW-1:0]   addr_q;
    logic            rd_valid;
    logic [1:0]      buf_count;
    logic [DW-1:0]   head_q;
    logic [DW-1:0]   tail_q;
    logic            pop;
    logic            issue;
    logic            last_pop;

    // A read is "issued" in the cycle its address is presented; its data lands
    // in the buffer one cycle later, so only rd_valid counts as in flight.
    always_comb begin
        pop       = (buf_count != 2'd0) && in_ready;
        issue     = (state == RUN) && (issued_q < len_q) &&
                    ((({1'b0, buf_count} + {2'b00, rd_valid}) < 3'd2) || pop);
        last_pop  = pop && (delivered_q == (len_q - (AW+1)'(1)));
        state_nxt = state;
        case (state)
            IDLE: if (in_start) state_nxt = (in_length == '0) ? DONE : RUN;
            RUN:  if (last_pop) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            addr_q      <= '0;
            rd_valid    <= 1'b0;
        end else begin
            if (state == IDLE && in_start) begin
                len_q       <= in_length;
                addr_q      <= in_base_addr;
                issued_q    <= '0;
                delivered_q <= '0;
            end
            if (issue) begin
                addr_q   <= addr_q + AW'(1);
                issued_q <= issued_q + (AW+1)'(1);
            end
            if (pop) delivered_q <= delivered_q + (AW+1)'(1);
            rd_valid <= issue;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            buf_count <= '0;
            head_q    <= '0;
            tail_q    <= '0;
        end else begin
            case ({rd_valid, pop})
                2'b10: begin
                    if (buf_count == 2'd0) head_q <= in_ram_data;
                    else                   tail_q <= in_ram_data;
                    buf_count <= buf_count + 2'd1;
                end
                2'b01: begin
                    if (buf_count == 2'd2) head_q <= tail_q;
                    buf_count <= buf_count - 2'd1;
                end
                2'b11: begin
                    if (buf_count == 2'd1) begin
                        head_q <= in_ram_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= in_ram_data;
                    end
                end
                default: ;
            endcase
        end
    end

    buf_no_overflow: assert property (@(posedge in_clk) disable iff (!in_rst_n)
        (({1'b0, buf_count} + {2'b00, rd_valid}) <= 3'd2));

    assign out_busy     = (state != IDLE);
    assign out_done     = (state == DONE);
    assign out_ram_addr = addr_q;
    assign out_ram_wr   = 1'b0;
    assign out_data     = head_q;
    assign out_valid    = (buf_count != 2'd0);

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader against a registered-read RAM model holding mem[k] = k.
module tb_ram_stream_reader;

    logic       in_clk;
    logic       in_rst_n;
    logic       in_start;
    logic [7:0] in_base_addr;
    logic [8:0] in_length;
    logic       out_busy;
    logic       out_done;
    logic [7:0] out_ram_addr;
    logic       out_ram_wr;
    logic [7:0] in_ram_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       in_ready;

    logic [7:0] mem [256];
    int         n_assert = 0;
    int         n_fail   = 0;

    ram_stream_reader #(.RAM_ADDR_WIDTH(8), .RAM_DATA_WIDTH(8)) dut (
        .in_clk       (in_clk),
        .in_rst_n     (in_rst_n),
        .in_start     (in_start),
        .in_base_addr (in_base_addr),
        .in_length    (in_length),
        .out_busy     (out_busy),
        .out_done     (out_done),
        .out_ram_addr (out_ram_addr),
        .out_ram_wr   (out_ram_wr),
        .in_ram_data  (in_ram_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .in_ready     (in_ready)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    always @(posedge in_clk) in_ram_data <= mem[out_ram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    // Runs one transfer to completion, checking order, stall stability and done count.
    task automatic collect(input logic [7:0] base, input logic [8:0] len,
                           input bit toggle, input bit mid_start);
        int         got;
        int         dones;
        int         busy_cyc;
        int         cyc;
        bit         prev_stall;
        logic [7:0] prev_data;
        logic [7:0] exp_data;
        logic [5:0] pat;
        pat        = 6'b101001;
        got        = 0;
        dones      = 0;
        busy_cyc   = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        in_ready     = 1'b1;
        in_base_addr = base;
        in_length    = len;
        in_start     = 1'b1;
        step();
        in_start = 1'b0;
        while (out_busy && cyc < int'(len) + 40) begin
            in_ready = toggle ? pat[cyc % 6] : 1'b1;
            if (mid_start) begin
                in_start     = (cyc == 3);
                in_base_addr = 8'h80;
                in_length    = 9'd3;
            end
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
            end
            chk("buf_count_le2", 32'(dut.buf_count <= 2'd2), 32'd1);
            if (out_done) dones++;
            busy_cyc++;
            if (out_valid && in_ready) begin
                exp_data = base + 8'(got);
                chk("data", 32'(out_data), 32'(exp_data));
                got++;
            end
            prev_stall = out_valid && !in_ready;
            prev_data  = out_data;
            cyc++;
            step();
        end
        in_start = 1'b0;
        in_ready = 1'b1;
        chk("no_timeout", 32'(out_busy), 32'd0);
        chk("word_count", 32'(got), 32'(len));
        chk("done_count", 32'(dones), 32'd1);
        if (len == 9'd0) chk("len0_busy_cycles", 32'(busy_cyc), 32'd1);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 8'(k);
        in_rst_n     = 1'b0;
        in_start     = 1'b0;
        in_base_addr = '0;
        in_length    = '0;
        in_ready     = 1'b0;
        #22;
        chk("rst_busy", 32'(out_busy), 32'd0);
        chk("rst_done", 32'(out_done), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_addr", 32'(out_ram_addr), 32'd0);
        chk("rst_wr", 32'(out_ram_wr), 32'd0);
        in_rst_n = 1'b1;
        step();

        // Test 1: exact cycle timing, base 0x10, len 4.
        in_ready     = 1'b1;
        in_base_addr = 8'h10;
        in_length    = 9'd4;
        in_start     = 1'b1;
        step();
        in_start = 1'b0;
        chk("t1_e0_busy", 32'(out_busy), 32'd1);
        chk("t1_e0_addr", 32'(out_ram_addr), 32'h10);
        chk("t1_e0_valid", 32'(out_valid), 32'd0);
        step();
        chk("t1_e1_valid", 32'(out_valid), 32'd0);
        chk("t1_e1_addr", 32'(out_ram_addr), 32'h11);
        step();
        chk("t1_e2_valid", 32'(out_valid), 32'd1);
        chk("t1_e2_data", 32'(out_data), 32'h10);
        step();
        chk("t1_e3_data", 32'(out_data), 32'h11);
        chk("t1_e3_done", 32'(out_done), 32'd0);
        step();
        chk("t1_e4_data", 32'(out_data), 32'h12);
        step();
        chk("t1_e5_data", 32'(out_data), 32'h13);
        chk("t1_e5_valid", 32'(out_valid), 32'd1);
        chk("t1_e5_done", 32'(out_done), 32'd0);
        step();
        chk("t1_e6_done", 32'(out_done), 32'd1);
        chk("t1_e6_busy", 32'(out_busy), 32'd1);
        chk("t1_e6_valid", 32'(out_valid), 32'd0);
        step();
        chk("t1_e7_done", 32'(out_done), 32'd0);
        chk("t1_e7_busy", 32'(out_busy), 32'd0);
        chk("t1_wr", 32'(out_ram_wr), 32'd0);

        // Test 2: address wrap.
        collect(8'hFE, 9'd4, 1'b0, 1'b0);
        chk("t2_addr_after", 32'(out_ram_addr), 32'h02);

        // Test 3: ready toggling.
        collect(8'h30, 9'd6, 1'b1, 1'b0);

        // Test 4: zero length.
        collect(8'h55, 9'd0, 1'b0, 1'b0);
        chk("t4_addr_unmoved", 32'(out_ram_addr), 32'h55);

        // Test 5: start during transfer ignored, then back-to-back start.
        collect(8'h40, 9'd8, 1'b0, 1'b1);
        collect(8'h50, 9'd3, 1'b1, 1'b0);

        // Full-depth transfer returns address to base.
        collect(8'h33, 9'd256, 1'b0, 1'b0);
        chk("full_addr_back", 32'(out_ram_addr), 32'h33);

        // Test 6: reset after 3 of 8 words.
        in_ready     = 1'b1;
        in_base_addr = 8'h20;
        in_length    = 9'd8;
        in_start     = 1'b1;
        step();
        in_start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("t6_pre_data", 32'(out_data), 32'h23);
        in_rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(out_busy), 32'd0);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_data", 32'(out_data), 32'd0);
        chk("t6_rst_addr", 32'(out_ram_addr), 32'd0);
        chk("t6_rst_done", 32'(out_done), 32'd0);
        step();
        in_rst_n = 1'b1;
        step();
        chk("t6_post_done", 32'(out_done), 32'd0);
        chk("t6_post_busy", 32'(out_busy), 32'd0);
        collect(8'h20, 9'd8, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
